can_encoder: RTL

//  CAN 2.0A/B frame transmitter: the transmit-side counterpart of can_decoder/can_destuffing.

---
 rtl/can_encoder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/can_encoder.sv
// can_encoder: CAN 2.0A/B frame transmitter (standard or extended ID, data or remote frame).
// Builds the frame field by field, computes the CRC-15 on the fly, inserts stuff bits and drives
// one NRZ bit for CLKS_PER_BIT clocks. Bit_Output = 1 is recessive.
// Optional feature: define CAN_ARBITRATION_EN to enable bus readback during arbitration. When it
// is enabled, a recessive bit read back as dominant aborts the frame and pulses o_Arb_Lost.
module can_encoder #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        Clock_TB,
  input  logic        Reset,
  input  logic        i_Start,
  input  logic        i_Estendido_Flag,
  input  logic        i_Data_Flag,
  input  logic [3:0]  i_Data_Lenth,
  input  logic [28:0] i_ID_Field,
  input  logic [63:0] i_Data_Field,
  input  logic        Bit_Input,
  output logic        Bit_Output,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Arb_Lost
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        bit_q, bit_d;
  logic [2:0]  run_q, run_d;
  logic [14:0] crc_q, crc_d;

  logic        ext_q, dflag_q;
  logic [3:0]  dlc_q;
  logic [28:0] id_q;
  logic [63:0] data_q;

  logic [6:0]  data_bits, field_len;
  logic        last_in_field, bit_end, stuff_due, arb_lost_det;
  state_t      succ_state, adv_state;
  logic [5:0]  adv_idx;
  logic        adv_bit;

  // One CRC-15 (poly 0x4599) step, MSB first.
  function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = crc[14] ^ b;
    crc_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  // Unstuffed bit at position ix of field st; everything past the CRC is recessive.
  function automatic logic frame_bit(input state_t st, input logic [5:0] ix, input logic ext,
                                     input logic dflag, input logic [3:0] dlc,
                                     input logic [28:0] id, input logic [63:0] data,
                                     input logic [14:0] crc);
    logic b;
    b = 1'b1;
    case (st)
      S_SOF: b = 1'b0;
      S_ARB: begin
        if (!ext) begin
          if (ix == 6'd11) b = ~dflag;
          else             b = id[5'd10 - ix[4:0]];
        end else begin
          if (ix <= 6'd10)      b = id[5'd28 - ix[4:0]];
          else if (ix <= 6'd12) b = 1'b1;                  // SRR, IDE
          else if (ix <= 6'd30) b = id[5'd30 - ix[4:0]];
          else                  b = ~dflag;                // RTR
        end
      end
      S_CTRL: begin
        case (ix)
          6'd2:    b = dlc[3];
          6'd3:    b = dlc[2];
          6'd4:    b = dlc[1];
          6'd5:    b = dlc[0];
          default: b = 1'b0;                               // IDE/r1, r0
        endcase
      end
      S_DATA:  b = data[~ix];
      S_CRC:   b = crc[4'd14 - ix[3:0]];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

`ifdef CAN_ARBITRATION_EN
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  logic arb_lost_q;

  assign arb_lost_det = (state_q == S_ARB) && (cnt_q == CNT_HALF) && bit_q && !Bit_Input;

  // Registers the one-clock arbitration-loss pulse
  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) arb_lost_q <= 1'b0;
    else       arb_lost_q <= arb_lost_det;
  end

  assign o_Arb_Lost = arb_lost_q;
`else
  logic unused_bit_input;
  assign unused_bit_input = Bit_Input;
  assign arb_lost_det     = 1'b0;
  assign o_Arb_Lost       = 1'b0;
`endif

  // State register: FSM, bit position, bit timer, stuffing run and CRC
  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b1;
      run_q   <= '0;
      crc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      run_q   <= run_d;
      crc_q   <= crc_d;
    end
  end

  // Captures the frame request on the accepting start edge; later input changes are ignored
  always_ff @(posedge Clock_TB) begin
    if (state_q == S_IDLE && i_Start) begin
      ext_q   <= i_Estendido_Flag;
      dflag_q <= i_Data_Flag;
      dlc_q   <= i_Data_Lenth;
      id_q    <= i_ID_Field;
      data_q  <= i_Data_Field;
    end
  end

  // Next-state: advance one bus bit per CLKS_PER_BIT clocks, inserting stuff bits when due
  always_comb begin
    data_bits = !dflag_q ? 7'd0 : (dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000});
    case (state_q)
      S_SOF:   field_len = 7'd1;
      S_ARB:   field_len = ext_q ? 7'd32 : 7'd12;
      S_CTRL:  field_len = 7'd6;
      S_DATA:  field_len = data_bits;
      S_CRC:   field_len = 7'd15;
      S_EOF:   field_len = 7'd7;
      S_IFS:   field_len = 7'd3;
      default: field_len = 7'd1;
    endcase
    case (state_q)
      S_SOF:     succ_state = S_ARB;
      S_ARB:     succ_state = S_CTRL;
      S_CTRL:    succ_state = (data_bits == 7'd0) ? S_CRC : S_DATA;
      S_DATA:    succ_state = S_CRC;
      S_CRC:     succ_state = S_CRC_DEL;
      S_CRC_DEL: succ_state = S_ACK;
      S_ACK:     succ_state = S_ACK_DEL;
      S_ACK_DEL: succ_state = S_EOF;
      S_EOF:     succ_state = S_IFS;
      default:   succ_state = S_IDLE;
    endcase
    last_in_field = ({1'b0, idx_q} == field_len - 7'd1);
    bit_end       = (cnt_q == CNT_LAST);
    stuff_due     = (state_q inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC}) && (run_q == 3'd5);
    adv_state     = last_in_field ? succ_state : state_q;
    adv_idx       = last_in_field ? 6'd0 : idx_q + 6'd1;
    adv_bit       = frame_bit(adv_state, adv_idx, ext_q, dflag_q, dlc_q, id_q, data_q, crc_q);

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    run_d   = run_q;
    crc_d   = crc_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (i_Start) begin
        state_d = S_SOF;
        idx_d   = '0;
        bit_d   = 1'b0;
        run_d   = 3'd1;
        crc_d   = '0;               // SOF is dominant, so its CRC step leaves zero
      end
    end else if (arb_lost_det) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      bit_d   = 1'b1;
      run_d   = '0;
      crc_d   = '0;
    end else if (bit_end) begin
      cnt_d = '0;
      if (stuff_due) begin
        // Stuff bit: position does not advance, CRC untouched, it starts the new run
        bit_d = ~bit_q;
        run_d = 3'd1;
      end else begin
        state_d = adv_state;
        idx_d   = adv_idx;
        bit_d   = adv_bit;
        if (adv_bit != bit_q)    run_d = 3'd1;
        else if (run_q == 3'd7)  run_d = 3'd7;
        else                     run_d = run_q + 3'd1;
        if (adv_state inside {S_SOF, S_ARB, S_CTRL, S_DATA})
          crc_d = crc_step(crc_q, adv_bit);
        if (adv_state == S_IDLE) begin
          bit_d = 1'b1;
          run_d = '0;
          crc_d = '0;
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs: bus bit, busy, and end-of-intermission pulse on the last clock of IFS
  always_comb begin
    Bit_Output = bit_q;
    o_Busy     = (state_q != S_IDLE);
    o_Done     = (state_q == S_IFS) && last_in_field && bit_end;
  end

endmodule
